// File: rtl/mips_fetch_unit.sv
// Instruction fetch front end: sequential fetch over req/ack, prefetch queue, redirect flush.
// Optional starvation counter enabled by defining FETCH_STALL_CNT_EN.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        ClkIn,
  input  logic        Rst,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemData,
  output logic        InstValid,
  input  logic        InstReady,
  output logic [31:0] Instruction,
  output logic [31:0] PC,
  input  logic        Redirect,
  input  logic [29:0] PCBranch,
  output logic [31:0] StallCount
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

  logic [31:0]   q_pc    [QDEPTH];
  logic [31:0]   q_instr [QDEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_addr;
  logic          outstanding;
  logic          squash;

  logic issue;
  logic ack_fire;
  logic push;
  logic pop;

  always_comb begin
    issue    = Rst & (outstanding | (count < QFULL));
    ack_fire = issue & ImemAck;
    push     = ack_fire & ~squash & ~Redirect;
    pop      = (count != '0) & InstReady & ~Redirect;
  end

  // A squashed request keeps presenting its original address even though
  // fetch_pc already holds the redirect target.
  assign ImemReq     = issue;
  assign ImemAddr    = outstanding ? req_addr : fetch_pc;
  assign InstValid   = (count != '0);
  assign PC          = q_pc[head];
  assign Instruction = q_instr[head];

  always_ff @(posedge ClkIn or negedge Rst) begin
    if (!Rst) begin
      fetch_pc    <= RESET_PC;
      req_addr    <= RESET_PC;
      outstanding <= 1'b0;
      squash      <= 1'b0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
      end
    end else begin
      outstanding <= issue & ~ImemAck;
      if (!outstanding) begin
        req_addr <= fetch_pc;
      end
      if (Redirect) begin
        fetch_pc <= {PCBranch, 2'b00};
        squash   <= issue & ~ImemAck;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
      end else begin
        if (ack_fire) begin
          squash <= 1'b0;
        end
        if (push) begin
          q_pc[tail]    <= fetch_pc;
          q_instr[tail] <= ImemData;
          tail          <= tail + PW'(1);
          fetch_pc      <= fetch_pc + 32'd4;
        end
        if (pop) begin
          head <= head + PW'(1);
        end
        if (push && !pop) begin
          count <= count + CW'(1);
        end else if (pop && !push) begin
          count <= count - CW'(1);
        end
      end
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge ClkIn or negedge Rst) begin
    if (!Rst) begin
      stall_cnt <= '0;
    end else if ((count == '0) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign StallCount = stall_cnt;
`else
  assign StallCount = '0;
`endif

endmodule

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

Instruction fetch front end for the single-clock MIPS core. It generates sequential word addresses, fetches from instruction memory over a req/ack handshake that tolerates variable latency, and buffers fetched words in a small prefetch queue. The queue feeds decode through a valid/ready interface. Branch and jump redirects from the execute stage flush the queue and restart fetch at the target.

## Interface
Parameters:
- RESET_PC, default 32'h0000_0000: first fetch address after reset; must be word-aligned.
- QDEPTH, default 2: prefetch queue entries; power of two, range 2..8.

Ports:
- ClkIn  in  1  : system clock; all state updates on rising edge.
- Rst  in  1  : asynchronous, active-low reset.
- ImemReq  out  1  : fetch request to instruction memory.
- ImemAddr  out  32  : byte address of the request; stable while ImemReq is high.
- ImemAck  in  1  : memory returns data this cycle; may be high in the same cycle ImemReq rises.
- ImemData  in  32  : instruction word; valid when ImemAck is high.
- InstValid  out  1  : queue head holds a valid instruction.
- InstReady  in  1  : decode accepts the head this cycle.
- Instruction  out  32  : queue head instruction word.
- PC  out  32  : byte address of the queue head instruction.
- Redirect  in  1  : flush the queue and restart fetch.
- PCBranch  in  30  : redirect target, as a word address; byte target is {PCBranch, 2'b00}.
- StallCount  out  32  : count of front-end starvation cycles. See Configuration.

## Operation
- State:
  - FetchPC: 32-bit register.
  - Queue: QDEPTH entries of {pc, instr}, with head pointer, tail pointer and count.
  - Outstanding flag.
  - Squash flag.
- Issue rule: ImemReq = Rst & (Outstanding | (count < QDEPTH)).
  - Credit includes the in-flight fetch, so a push can never overflow the queue.
  - ImemAddr = FetchPC.
- Handshake: once raised, ImemReq stays high with ImemAddr frozen until ImemAck is sampled high. The request is never withdrawn.
- On ImemAck:
  - Outstanding clears.
  - If Squash is 0: push {FetchPC, ImemData} and set FetchPC <= FetchPC + 4, wrapping 32'hFFFF_FFFC -> 0.
  - If Squash is 1: discard the data, clear Squash, and leave FetchPC unchanged (it already holds the redirect target).
- Output side:
  - InstValid = (count != 0).
  - Instruction and PC come combinationally from the head entry.
  - Pop when InstValid & InstReady.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Redirect has highest priority:
  - count <= 0 and pointers reset. A pop in the same cycle is treated as consumed.
  - FetchPC <= {PCBranch, 2'b00}.
  - If a request is outstanding and ImemAck is not high this cycle, set Squash.
  - If ImemAck is high in the same cycle, its data is dropped.
- Redirect while Squash is already set: retarget FetchPC; Squash stays set.
- Reset, asynchronous, including mid-fetch:
  - ImemReq 0, InstValid 0.
  - FetchPC, and therefore ImemAddr, = RESET_PC.
  - PC 0, Instruction 0.
  - Outstanding 0, Squash 0, StallCount 0.
  - Any pending memory response is the memory model's responsibility to abort.

## Timing
- Cycle 0 after Rst rises: ImemReq = 1 with ImemAddr = RESET_PC.
- Zero-wait memory (ImemAck in the same cycle): the instruction appears at InstValid/Instruction in the following cycle, so fetch-to-decode latency is 1 cycle.
- Throughput: with zero-wait memory and InstReady held high, one instruction per cycle is sustained for QDEPTH >= 2.
- N-wait memory: one instruction per N+1 cycles. There is a single outstanding request, and issue decisions use registered count only, with no pop bypass.
- Redirect in cycle t:
  - Queue is empty in t+1.
  - A new request to the target issues in t+1 if nothing is outstanding.
  - Otherwise it issues in the cycle after the squashed ack.

## Configuration
- FETCH_STALL_CNT_EN defined: StallCount increments every cycle with Rst high and InstValid 0. It saturates at 32'hFFFF_FFFF and clears only on reset.
- Macro undefined: the counter logic is omitted and StallCount is tied to 32'h0.

## Test plan
- Reset release, zero-wait memory, InstReady=1, RESET_PC=0:
  - PC sequence 0x0, 0x4, 0x8, … on consecutive cycles starting 1 cycle after release.
  - ImemAddr matches each fetch.
- InstReady=0 with zero-wait memory:
  - Queue fills to QDEPTH=2 (PC 0x0 and 0x4 held).
  - ImemReq drops.
  - Raising InstReady resumes with 0x8 and no duplicated or lost PC.
- 3-wait memory, Redirect with PCBranch=30'h40 asserted while a request to 0x8 is pending:
  - The ack for 0x8 is discarded.
  - The next ImemAddr is 0x100.
  - The first delivered PC is 0x100.
- Redirect in the same cycle as ImemAck and a pop:
  - The acked word is never delivered.
  - The queue is empty the next cycle.
  - Fetch restarts at the target.
- FetchPC=0xFFFF_FFFC via Redirect (PCBranch=30'h3FFF_FFFF): delivered PCs are 0xFFFF_FFFC then 0x0.
- Rst pulled low mid-wait with the request outstanding: all outputs reach their reset values immediately. With FETCH_STALL_CNT_EN, StallCount reads 0 after reset and counts the N-wait starvation cycles exactly.
